// File: rtl/branch_hazard_controller_pkg.sv
// Shared definitions for the ID-stage branch hazard controller:
// branch flag codes, FSM state encoding, default widths and a flag
// classification helper used by the top level.
package branch_hazard_controller_pkg;

  localparam int ADDR_W     = 11;
  localparam int FLAG_W     = 3;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 32;

  // Branch flag codes produced by the ID-stage decoder.
  // Codes 6 and 7 are unused and behave like FLAG_NONE.
  localparam int FLAG_NONE = 0;
  localparam int FLAG_JR   = 1;
  localparam int FLAG_JALR = 2;
  localparam int FLAG_BEQ  = 3;
  localparam int FLAG_BNE  = 4;
  localparam int FLAG_J    = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT     = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  // True for every flag that can redirect the PC (JR, JALR, BEQ, BNE, J/JAL).
  function automatic logic is_branch_flag(input int unsigned flag);
    return (flag >= FLAG_JR) && (flag <= FLAG_J);
  endfunction

endpackage

// File: rtl/branch_hazard_controller_if.sv
// Bundle between the ID-stage branch logic / pipeline latches and the
// branch hazard controller. master = ID-stage side (drives i_*),
// slave = controller (drives o_*).
interface branch_hazard_controller_if
  import branch_hazard_controller_pkg::*;
#(
  parameter int CANT_BITS_ADDR        = ADDR_W,
  parameter int CANT_BITS_FLAG_BRANCH = FLAG_W,
  parameter int CANT_BITS_REG_ADDR    = REG_ADDR_W,
  parameter int CANT_BITS_CONTADOR    = CNT_W
);
  // branch calculator / ID fields
  logic [CANT_BITS_FLAG_BRANCH-1:0] i_flag_branch;
  logic                             i_branch_control;
  logic [CANT_BITS_ADDR-1:0]        i_branch_dir;
  logic [CANT_BITS_REG_ADDR-1:0]    i_rs;
  logic [CANT_BITS_REG_ADDR-1:0]    i_rt;
  // downstream producers
  logic                             i_ex_reg_write;
  logic [CANT_BITS_REG_ADDR-1:0]    i_ex_rd;
  logic                             i_mem_mem_read;
  logic [CANT_BITS_REG_ADDR-1:0]    i_mem_rd;
  // controls towards PC and pipeline latches
  logic                             o_stall;
  logic                             o_pc_load;
  logic [CANT_BITS_ADDR-1:0]        o_pc_dir;
  logic                             o_flush_if_id;
  logic                             o_flush_id_ex;
  // debug counters
  logic [CANT_BITS_CONTADOR-1:0]    o_branch_count;
  logic [CANT_BITS_CONTADOR-1:0]    o_stall_count;

  modport master (
    output i_flag_branch, i_branch_control, i_branch_dir, i_rs, i_rt,
           i_ex_reg_write, i_ex_rd, i_mem_mem_read, i_mem_rd,
    input  o_stall, o_pc_load, o_pc_dir, o_flush_if_id, o_flush_id_ex,
           o_branch_count, o_stall_count
  );

  modport slave (
    input  i_flag_branch, i_branch_control, i_branch_dir, i_rs, i_rt,
           i_ex_reg_write, i_ex_rd, i_mem_mem_read, i_mem_rd,
    output o_stall, o_pc_load, o_pc_dir, o_flush_if_id, o_flush_id_ex,
           o_branch_count, o_stall_count
  );

endinterface

// File: rtl/branch_hazard_controller_hazard_detector.sv
// Purpose: detects RAW hazards on branch source operands still in EX / MEM.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs feed the controller's stall decision.
// Ports: i_flag_branch/i_rs/i_rt from ID; i_ex_*/i_mem_* from later stages;
//        o_hz_ex/o_hz_mem hazard flags.
module branch_operand_hazard_detector
  import branch_hazard_controller_pkg::*;
#(
  parameter int CANT_BITS_FLAG_BRANCH = FLAG_W,
  parameter int CANT_BITS_REG_ADDR    = REG_ADDR_W
) (
  input  logic [CANT_BITS_FLAG_BRANCH-1:0] i_flag_branch,
  input  logic [CANT_BITS_REG_ADDR-1:0]    i_rs,
  input  logic [CANT_BITS_REG_ADDR-1:0]    i_rt,
  input  logic                             i_ex_reg_write,
  input  logic [CANT_BITS_REG_ADDR-1:0]    i_ex_rd,
  input  logic                             i_mem_mem_read,
  input  logic [CANT_BITS_REG_ADDR-1:0]    i_mem_rd,
  output logic                             o_hz_ex,
  output logic                             o_hz_mem
);

  logic uses_rs;
  logic uses_rt;
  logic ex_match;
  logic mem_match;

  always_comb begin
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    case (32'(i_flag_branch))
      FLAG_JR, FLAG_JALR: uses_rs = 1'b1;
      FLAG_BEQ, FLAG_BNE: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      default: ;  // J/JAL and unused codes read no registers
    endcase
  end

  assign ex_match  = (uses_rs && (i_ex_rd == i_rs)) || (uses_rt && (i_ex_rd == i_rt));
  assign mem_match = (uses_rs && (i_mem_rd == i_rs)) || (uses_rt && (i_mem_rd == i_rt));

  // $zero is hardwired, so a write to it never produces a dependency.
  assign o_hz_ex  = i_ex_reg_write && (i_ex_rd != '0) && ex_match;
  assign o_hz_mem = i_mem_mem_read && (i_mem_rd != '0) && mem_match;

endmodule

// File: rtl/branch_hazard_controller.sv
// Purpose: ID-stage branch sequencing: operand stall, one-cycle PC redirect + flushes, debug counters.
// Latency: taken branch in enabled cycle N -> pc_load/flushes registered in cycle N+1; not-taken costs 0.
// Backpressure: i_enable=0 freezes state, target and counters; a pending redirect stays asserted.
// Ports: i_clock, i_reset (async active-low), i_enable; bus (slave) carries branch inputs,
//        producer info, stall/redirect/flush controls and the two debug counters.
module branch_hazard_controller
  import branch_hazard_controller_pkg::*;
#(
  parameter int CANT_BITS_ADDR        = ADDR_W,
  parameter int CANT_BITS_FLAG_BRANCH = FLAG_W,
  parameter int CANT_BITS_REG_ADDR    = REG_ADDR_W,
  parameter int CANT_BITS_CONTADOR    = CNT_W
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_enable,
  branch_hazard_controller_if.slave   bus
);

  state_e                        state_q, state_d;
  logic [CANT_BITS_ADDR-1:0]     pc_dir_q, pc_dir_d;
  logic                          redirect_q, redirect_d;
  logic [CANT_BITS_CONTADOR-1:0] branch_cnt_q, branch_cnt_d;
  logic [CANT_BITS_CONTADOR-1:0] stall_cnt_q, stall_cnt_d;

  logic hz_ex;
  logic hz_mem;
  logic hazard;
  logic taken;
  logic stall;

  branch_operand_hazard_detector #(
    .CANT_BITS_FLAG_BRANCH (CANT_BITS_FLAG_BRANCH),
    .CANT_BITS_REG_ADDR    (CANT_BITS_REG_ADDR)
  ) u_hazard_detector (
    .i_flag_branch  (bus.i_flag_branch),
    .i_rs           (bus.i_rs),
    .i_rt           (bus.i_rt),
    .i_ex_reg_write (bus.i_ex_reg_write),
    .i_ex_rd        (bus.i_ex_rd),
    .i_mem_mem_read (bus.i_mem_mem_read),
    .i_mem_rd       (bus.i_mem_rd),
    .o_hz_ex        (hz_ex),
    .o_hz_mem       (hz_mem)
  );

  assign hazard = hz_ex || hz_mem;
  assign taken  = is_branch_flag(32'(bus.i_flag_branch)) && bus.i_branch_control;

  // Gated by i_reset so the stall drops together with the async reset,
  // instead of reasserting from a hazard still present on the inputs.
  assign stall = i_reset && i_enable && hazard &&
                 ((state_q == ST_RUN) || (state_q == ST_WAIT));

  always_comb begin
    state_d      = state_q;
    pc_dir_d     = pc_dir_q;
    branch_cnt_d = branch_cnt_q;
    stall_cnt_d  = stall_cnt_q;

    if (i_enable) begin
      case (state_q)
        ST_RUN, ST_WAIT: begin
          if (hazard) begin
            state_d = ST_WAIT;
          end else if (taken) begin
            state_d      = ST_REDIRECT;
            pc_dir_d     = bus.i_branch_dir;
            branch_cnt_d = branch_cnt_q + CANT_BITS_CONTADOR'(1);
          end else begin
            state_d = ST_RUN;
          end
        end
        // The instruction now in ID is wrong-path: ignore its flag/hazards.
        ST_REDIRECT: state_d = ST_RUN;
        default:     state_d = ST_RUN;
      endcase
    end

    if (stall) begin
      stall_cnt_d = stall_cnt_q + CANT_BITS_CONTADOR'(1);
    end

    // Dedicated flop so pc_load/flushes come straight from a register.
    redirect_d = (state_d == ST_REDIRECT);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= ST_RUN;
      pc_dir_q     <= '0;
      redirect_q   <= 1'b0;
      branch_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_dir_q     <= pc_dir_d;
      redirect_q   <= redirect_d;
      branch_cnt_q <= branch_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.o_stall        = stall;
  assign bus.o_pc_load      = redirect_q;
  assign bus.o_flush_if_id  = redirect_q;
  assign bus.o_flush_id_ex  = redirect_q;
  assign bus.o_pc_dir       = pc_dir_q;
  assign bus.o_branch_count = branch_cnt_q;
  assign bus.o_stall_count  = stall_cnt_q;

endmodule
